// File: rtl/polyveck_reduce_seq.sv
// Sequential reduce32 over a K-polynomial vector, LANES coefficients per beat.
// Define POLYVECK_REDUCE_CADDQ_EN to add Q to negative results (output in [0, Q)).
module polyveck_reduce_seq #(
    parameter int K     = 6,
    parameter int N     = 256,
    parameter int LANES = 8,
    parameter int Q     = 8380417
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [K*N*32-1:0]  v_in,
    output logic [K*N*32-1:0]  v_out,
    output logic               done
);

    localparam int W  = K * N * 32;
    localparam int B  = (K * N) / LANES;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    localparam logic signed [32:0] QS   = 33'(Q);
    localparam logic signed [32:0] HALF = 33'sd4194304;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // 33-bit signed datapath: a + 2^22 and t*Q both fit without overflow
    function automatic logic [31:0] reduce32(input logic [31:0] a);
        logic signed [32:0] ax;
        logic signed [32:0] s;
        logic signed [32:0] t;
        logic signed [32:0] r;
        ax = signed'({a[31], a});
        s  = ax + HALF;
        t  = s >>> 23;
        r  = ax - t * QS;
`ifdef POLYVECK_REDUCE_CADDQ_EN
        if (r[31]) begin
            r = r + QS;
        end
`endif
        return r[31:0];
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                work_d  = v_in;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[(int'(cnt_q) * LANES + l) * 32 +: 32] =
                        reduce32(work_q[(int'(cnt_q) * LANES + l) * 32 +: 32]);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(B - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    assign v_out = work_q;

endmodule

// File: tb/tb_polyveck_reduce_seq.sv
// Directed bench for polyveck_reduce_seq: reset, boundaries, handshake,
// input capture, and LANES=1/16 latency variants.
module tb_polyveck_reduce_seq;

    localparam int K  = 6;
    localparam int N  = 256;
    localparam int M  = K * N;
    localparam int W  = M * 32;
    localparam int QV = 8380417;

    logic         clock;
    logic         reset;
    logic         start0, start1, start16;
    logic [W-1:0] v_in;
    logic [W-1:0] v_out0, v_out1, v_out16;
    logic         done0, done1, done16;

    logic [W-1:0] v_alt;
    logic [W-1:0] v_cap;
    logic [W-1:0] v_hold;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    polyveck_reduce_seq #(.K(K), .N(N), .LANES(8), .Q(QV)) dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .v_in(v_in), .v_out(v_out0), .done(done0)
    );

    polyveck_reduce_seq #(.K(K), .N(N), .LANES(1), .Q(QV)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .v_in(v_in), .v_out(v_out1), .done(done1)
    );

    polyveck_reduce_seq #(.K(K), .N(N), .LANES(16), .Q(QV)) dut16 (
        .clock(clock), .reset(reset), .start(start16),
        .v_in(v_in), .v_out(v_out16), .done(done16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: floor((a + 2^22) / 2^23) via truncating division plus fix-up
    function automatic logic [31:0] ref_reduce(input logic [31:0] a);
        longint s;
        longint t;
        longint r;
        s = longint'($signed(a)) + 64'sd4194304;
        t = s / 64'sd8388608;
        if (s < 0 && (s % 64'sd8388608) != 0) t = t - 1;
        r = longint'($signed(a)) - t * 64'sd8380417;
        return r[31:0];
    endfunction

    function automatic logic sel_done(input int sel);
        if (sel == 0) return done0;
        if (sel == 1) return done1;
        return done16;
    endfunction

    task automatic set_start(input int sel, input logic val);
        if (sel == 0) start0 = val;
        else if (sel == 1) start1 = val;
        else start16 = val;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, $signed(obs), $signed(exp));
        end
    endtask

    // Compare every coefficient of obs against the reference of src
    task automatic chk_vec(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] src);
        int bad;
        bad = 0;
        for (int m = 0; m < M; m++) begin
            if (obs[32*m +: 32] !== ref_reduce(src[32*m +: 32])) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Call with the DUT in IDLE; returns edges counted from the start-sampling edge
    task automatic run(input int sel, input int abort_at, input bit swap,
                       input bit pulse, output int n);
        set_start(sel, 1'b1);
        tick();
        n = 0;
        while (1) begin
            tick();
            n++;
            if (pulse && n == 1) set_start(sel, 1'b0);
            if (swap && n == 2) v_in = v_alt;
            if (abort_at > 0 && n == abort_at) break;
            if (sel_done(sel)) break;
            if (n >= 4000) break;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        start16 = 1'b0;
        v_in    = '0;
        v_alt   = '0;
        repeat (3) tick();
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_vout", 32'(v_out0 != '0), 32'd0);
        reset = 1'b0;

        // Abort in RUN at beat 50
        for (int m = 0; m < M; m++) v_in[32*m +: 32] = 32'(m + 1);
        run(0, 52, 1'b0, 1'b0, lat);
        chk("abort_reached", 32'(lat), 32'd52);
        reset  = 1'b1;
        start0 = 1'b0;
        tick();
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_vout", 32'(v_out0 != '0), 32'd0);
        reset = 1'b0;

        // All coefficients = Q except coefficient 0 = 0
        for (int m = 0; m < M; m++) v_in[32*m +: 32] = 32'(QV);
        v_in[31:0] = 32'd0;
        run(0, 0, 1'b0, 1'b0, lat);
        chk("q_latency", 32'(lat), 32'd194);
        chk("q_done", 32'(done0), 32'd1);
        chk("q_allzero", 32'(v_out0 != '0), 32'd0);
        start0 = 1'b0;
        tick();
        chk("q_done_drop", 32'(done0), 32'd0);

        // Extremes and rounding boundaries
        v_in = '0;
        v_in[32*0    +: 32] = 32'h7fffffff;
        v_in[32*1535 +: 32] = 32'h80000000;
        v_in[32*100  +: 32] = 32'd4194303;
        v_in[32*101  +: 32] = 32'd4194304;
        v_in[32*102  +: 32] = 32'hffffffff;
        v_in[32*103  +: 32] = 32'd8380417;
        v_in[32*7    +: 32] = -32'sd8380417;
        run(0, 0, 1'b0, 1'b0, lat);
        chk("bnd_latency", 32'(lat), 32'd194);
        chk("bnd_max", v_out0[32*0 +: 32], 32'd2096895);
        chk("bnd_min", v_out0[32*1535 +: 32], -32'sd2096896);
        chk("bnd_below_half", v_out0[32*100 +: 32], 32'd4194303);
        chk("bnd_half", v_out0[32*101 +: 32], -32'sd4186113);
        chk("bnd_minus1", v_out0[32*102 +: 32], 32'hffffffff);
        chk("bnd_q", v_out0[32*103 +: 32], 32'd0);
        chk("bnd_negq", v_out0[32*7 +: 32], 32'd0);
        chk("bnd_zero", v_out0[32*500 +: 32], 32'd0);

        // Start held high: done and v_out hold
        v_hold = v_out0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_done", 32'(done0), 32'd1);
            chk("hold_vout", 32'(v_out0 != v_hold), 32'd0);
        end
        start0 = 1'b0;
        tick();
        chk("hold_drop", 32'(done0), 32'd0);

        // One-cycle start pulse, v_in replaced after LOAD
        for (int m = 0; m < M; m++) begin
            v_in[32*m +: 32]  = $urandom;
            v_alt[32*m +: 32] = $urandom;
        end
        v_cap = v_in;
        run(0, 0, 1'b1, 1'b1, lat);
        chk("pulse_latency", 32'(lat), 32'd194);
        chk_vec("capture_l8", v_out0, v_cap);
        tick();
        chk("pulse_done_1cyc", 32'(done0), 32'd0);

        // LANES=1 and LANES=16 on the same captured vector
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v_in = v_cap;
        run(1, 0, 1'b1, 1'b0, lat);
        chk("l1_latency", 32'(lat), 32'd1538);
        chk_vec("capture_l1", v_out1, v_cap);
        start1 = 1'b0;
        tick();
        chk("l1_done_drop", 32'(done1), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        v_in = v_cap;
        run(2, 0, 1'b1, 1'b0, lat);
        chk("l16_latency", 32'(lat), 32'd98);
        chk_vec("capture_l16", v_out16, v_cap);
        start16 = 1'b0;
        tick();
        chk("l16_done_drop", 32'(done16), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
